// File: rtl/hazard_stall_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
package hazard_stall_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int WAIT_W          = 8;
endpackage

// File: rtl/hazard_stall_mem_wait_timer.sv
// Counts consecutive memory-hold cycles (saturating) and raises a sticky
// timeout flag once the count reaches MEM_TIMEOUT.
module mem_wait_timer
  import hazard_stall_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic memHold,
  output logic MemTimeout
);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);

  logic [WAIT_W-1:0] wait_cnt, wait_nxt;

  always_comb begin
    wait_nxt = '0;
    if (memHold) wait_nxt = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
  end

  // Flag is raised in the same edge that the count reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == LIMIT) MemTimeout <= 1'b1;
    end
  end
endmodule

// File: rtl/hazard_stall.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait
// stalls with deferred flush. Perf counters under HAZARD_PERF_CNT_EN.
module hazard_stall
  import hazard_stall_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MemTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] LoadStallCnt,
  output logic [CNT_W-1:0] MemStallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);
  state_t state;
  logic   flush_pend;
  logic   lw_haz, mem_hold, do_flush;

  assign lw_haz   = LoadE & RegWriteE & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));
  // MemReqM=0 also releases a wait, so a dropped request cannot hang the pipe.
  assign mem_hold = MemReqM & ~MemReadyM;
  assign do_flush = PCSrcE | ((state == MEM_WAIT) & flush_pend);

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (mem_hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (do_flush) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_haz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // A branch resolved while memory holds the pipe is remembered and applied
  // on the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          flush_pend <= mem_hold & PCSrcE;
          if (mem_hold) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_hold) begin
            flush_pend <= flush_pend | PCSrcE;
          end else begin
            flush_pend <= 1'b0;
            state      <= RUN;
          end
        end
        default: begin
          state      <= RUN;
          flush_pend <= 1'b0;
        end
      endcase
    end
  end

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .memHold   (mem_hold),
    .MemTimeout(MemTimeout)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic load_stall;
  assign load_stall = ~mem_hold & ~do_flush & lw_haz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LoadStallCnt <= '0;
      MemStallCnt  <= '0;
      FlushCnt     <= '0;
    end else begin
      LoadStallCnt <= LoadStallCnt + {{(CNT_W-1){1'b0}}, load_stall};
      MemStallCnt  <= MemStallCnt + {{(CNT_W-1){1'b0}}, StallM};
      FlushCnt     <= FlushCnt + {{(CNT_W-1){1'b0}}, FlushE};
    end
  end
`endif
endmodule

// File: tb/tb_hazard_stall.sv
// Directed bench for hazard_stall; counter checks active with HAZARD_PERF_CNT_EN.
module tb_hazard_stall;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       RegWriteE, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] LoadStallCnt, MemStallCnt, FlushCnt;
`endif

  int tests = 0, fails = 0;
  int exp_ls = 0, exp_ms = 0, exp_fl = 0;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  logic [5:0] outs;
  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE};
  localparam logic [5:0] NONE = 6'b000000, ALL_STALL = 6'b111100,
                         BR_FLUSH = 6'b000011, LD_STALL = 6'b110001;

  always #5 clk = ~clk;

  hazard_stall #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .RegWriteE(RegWriteE), .LoadE(LoadE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .MemTimeout(MemTimeout)
`ifdef HAZARD_PERF_CNT_EN
    , .LoadStallCnt(LoadStallCnt), .MemStallCnt(MemStallCnt), .FlushCnt(FlushCnt)
`endif
  );

  task automatic idle();
    Rs1D = 0; Rs2D = 0; RdE = 0; RegWriteE = 0; LoadE = 0;
    PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic load_haz();
    LoadE = 1; RegWriteE = 1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    @(negedge clk);
    tests++; if (outs !== NONE) begin fails++; $display("FAIL reset_outs got %b want %b", outs, NONE); end
    tests++; if (MemTimeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", MemTimeout); end
    load_haz(); #1;
    tests++; if (outs !== LD_STALL) begin fails++; $display("FAIL reset_lwhaz got %b want %b", outs, LD_STALL); end
    idle(); MemReqM = 1; #1;
    tests++; if (outs !== ALL_STALL) begin fails++; $display("FAIL reset_memhold got %b want %b", outs, ALL_STALL); end
    idle(); next_cycle(); rst_n = 1;
`ifdef HAZARD_PERF_CNT_EN
    tests++; if (MemStallCnt !== 0 || LoadStallCnt !== 0 || FlushCnt !== 0) begin
      fails++; $display("FAIL reset_cnts got %0d/%0d/%0d want 0/0/0", LoadStallCnt, MemStallCnt, FlushCnt); end
`endif
  endtask

  task automatic test_load_hazard();
    load_haz(); @(negedge clk);
    tests++; if (outs !== LD_STALL) begin fails++; $display("FAIL lw_rs1 got %b want %b", outs, LD_STALL); end
    exp_ls++; exp_fl++; next_cycle();
    idle(); @(negedge clk);
    tests++; if (outs !== NONE) begin fails++; $display("FAIL lw_clear got %b want %b", outs, NONE); end
    next_cycle();
    LoadE = 1; RegWriteE = 1; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd3; @(negedge clk);
    tests++; if (outs !== LD_STALL) begin fails++; $display("FAIL lw_rs2 got %b want %b", outs, LD_STALL); end
    exp_ls++; exp_fl++; next_cycle();
    RegWriteE = 0; @(negedge clk);
    tests++; if (outs !== NONE) begin fails++; $display("FAIL lw_nowrite got %b want %b", outs, NONE); end
    next_cycle();
    idle(); LoadE = 1; RegWriteE = 1; RdE = 0; Rs1D = 0; @(negedge clk);
    tests++; if (outs !== NONE) begin fails++; $display("FAIL lw_x0 got %b want %b", outs, NONE); end
    next_cycle(); idle();
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    tests++; if (LoadStallCnt !== exp_ls) begin fails++; $display("FAIL lw_cnt got %0d want %0d", LoadStallCnt, exp_ls); end
`endif
  endtask

  task automatic test_branch_override();
    load_haz(); PCSrcE = 1; @(negedge clk);
    tests++; if (outs !== BR_FLUSH) begin fails++; $display("FAIL br_over_lw got %b want %b", outs, BR_FLUSH); end
    exp_fl++; next_cycle(); idle();
  endtask

  task automatic test_mem_wait();
    for (int i = 1; i <= 3; i++) begin
      MemReqM = 1; MemReadyM = 0; @(negedge clk);
      tests++; if (outs !== ALL_STALL) begin fails++; $display("FAIL memwait_c%0d got %b want %b", i, outs, ALL_STALL); end
      exp_ms++; next_cycle();
    end
    MemReadyM = 1; @(negedge clk);
    tests++; if (outs !== NONE) begin fails++; $display("FAIL memwait_rel got %b want %b", outs, NONE); end
    next_cycle(); idle(); @(negedge clk);
    tests++; if (outs !== NONE) begin fails++; $display("FAIL memwait_after got %b want %b", outs, NONE); end
`ifdef HAZARD_PERF_CNT_EN
    tests++; if (MemStallCnt !== exp_ms) begin fails++; $display("FAIL memwait_cnt got %0d want %0d", MemStallCnt, exp_ms); end
`endif
    next_cycle();
  endtask

  task automatic test_flush_pending();
    for (int i = 1; i <= 4; i++) begin
      MemReqM = 1; MemReadyM = 0; PCSrcE = (i == 2); @(negedge clk);
      tests++; if (outs !== ALL_STALL) begin fails++; $display("FAIL pend_c%0d got %b want %b", i, outs, ALL_STALL); end
      exp_ms++; next_cycle();
    end
    PCSrcE = 0; MemReadyM = 1; @(negedge clk);
    tests++; if (outs !== BR_FLUSH) begin fails++; $display("FAIL pend_rel got %b want %b", outs, BR_FLUSH); end
    exp_fl++; next_cycle();
    idle(); @(negedge clk);
    tests++; if (outs !== NONE) begin fails++; $display("FAIL pend_cleared got %b want %b", outs, NONE); end
    next_cycle();
    // branch on the entry cycle, released by dropping the request
    MemReqM = 1; PCSrcE = 1; @(negedge clk);
    tests++; if (outs !== ALL_STALL) begin fails++; $display("FAIL entry_br got %b want %b", outs, ALL_STALL); end
    exp_ms++; next_cycle();
    MemReqM = 0; PCSrcE = 0; @(negedge clk);
    tests++; if (outs !== BR_FLUSH) begin fails++; $display("FAIL entry_rel got %b want %b", outs, BR_FLUSH); end
    exp_fl++; next_cycle();
    // load-use hazard resolved on the release cycle
    MemReqM = 1; MemReadyM = 0; @(negedge clk);
    exp_ms++; next_cycle();
    MemReadyM = 1; load_haz(); @(negedge clk);
    tests++; if (outs !== LD_STALL) begin fails++; $display("FAIL rel_lwhaz got %b want %b", outs, LD_STALL); end
    exp_ls++; exp_fl++; next_cycle(); idle();
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    tests++; if (FlushCnt !== exp_fl) begin fails++; $display("FAIL flush_cnt got %0d want %0d", FlushCnt, exp_fl); end
    tests++; if (LoadStallCnt !== exp_ls) begin fails++; $display("FAIL ls_cnt2 got %0d want %0d", LoadStallCnt, exp_ls); end
    tests++; if (MemStallCnt !== exp_ms) begin fails++; $display("FAIL ms_cnt2 got %0d want %0d", MemStallCnt, exp_ms); end
`endif
    next_cycle();
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 20; i++) begin
      MemReqM = 1; MemReadyM = 0; @(negedge clk);
      tests++; if (MemTimeout !== (i >= 17)) begin fails++; $display("FAIL tmo_c%0d got %b want %b", i, MemTimeout, (i >= 17)); end
      next_cycle();
    end
    MemReadyM = 1; @(negedge clk);
    tests++; if (outs !== NONE || MemTimeout !== 1'b1) begin
      fails++; $display("FAIL tmo_rel got %b/%b want %b/1", outs, MemTimeout, NONE); end
    next_cycle(); idle(); @(negedge clk);
    tests++; if (MemTimeout !== 1'b1) begin fails++; $display("FAIL tmo_sticky got %b want 1", MemTimeout); end
    next_cycle();
    for (int i = 1; i <= 3; i++) begin
      MemReqM = 1; MemReadyM = 0; PCSrcE = (i == 2); next_cycle();
    end
    PCSrcE = 0; rst_n = 0; @(negedge clk);
    tests++; if (MemTimeout !== 1'b0 || outs !== ALL_STALL) begin
      fails++; $display("FAIL tmo_rst got %b/%b want 0/%b", MemTimeout, outs, ALL_STALL); end
    next_cycle(); rst_n = 1; MemReadyM = 1; @(negedge clk);
    tests++; if (outs !== NONE) begin fails++; $display("FAIL rst_pend_drop got %b want %b", outs, NONE); end
    next_cycle();
    for (int i = 1; i <= 15; i++) begin
      MemReqM = 1; MemReadyM = 0; next_cycle();
    end
    MemReadyM = 1; @(negedge clk);
    tests++; if (MemTimeout !== 1'b0) begin fails++; $display("FAIL rst_wait_drop got %b want 0", MemTimeout); end
`ifdef HAZARD_PERF_CNT_EN
    tests++; if (MemStallCnt !== 15 || FlushCnt !== 0) begin
      fails++; $display("FAIL rst_cnts got %0d/%0d want 15/0", MemStallCnt, FlushCnt); end
`endif
    next_cycle(); idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_hazard();
    test_branch_override();
    test_mem_wait();
    test_flush_pending();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall.md
HAZARD_STALL -- requirements
Module: hazard_stall

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the number of consecutive memory-wait cycles after which a timeout is flagged (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, the width of the performance counters.
REQ-003 SHALL have port clk  in  1  the single clock; every flop is rising-edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports Rs1D, Rs2D  in  5 each  source registers of the decode-stage instruction.
REQ-006 SHALL have ports RdE (in, 5, execute destination), RegWriteE (in, 1), and LoadE (in, 1, execute instruction is a load).
REQ-007 SHALL have port PCSrcE  in  1  branch/jump taken in execute.
REQ-008 SHALL have ports MemReqM (in, 1, data-memory access in M) and MemReadyM (in, 1, data memory completes this cycle).
REQ-009 SHALL have outputs StallF, StallD, StallE, StallM, FlushD, FlushE (1 each) and MemTimeout (1, sticky error).
REQ-010 SHALL have outputs LoadStallCnt, MemStallCnt, FlushCnt (CNT_W each) when HAZARD_PERF_CNT_EN is defined.

Function
REQ-011 SHALL define lwHaz = LoadE & RegWriteE & (RdE != 0) & ((Rs1D == RdE) | (Rs2D == RdE)).
REQ-012 SHALL define memHold = MemReqM & ~MemReadyM.
REQ-013 SHALL have a two-state FSM, RUN and MEM_WAIT; stall and flush outputs are combinational from state and inputs, with zero-cycle latency.
REQ-014 RUN, memHold=1: SHALL assert StallF/D/E/M, deassert FlushD/E, and go to MEM_WAIT.
REQ-015 RUN, memHold=0, PCSrcE=1: SHALL assert FlushD and FlushE with no stalls; the branch overrides a simultaneous lwHaz.
REQ-016 RUN, memHold=0, PCSrcE=0, lwHaz=1: SHALL assert StallF, StallD and FlushE for each cycle lwHaz holds.
REQ-017 MEM_WAIT, MemReadyM=0: SHALL assert all four stalls and no flushes, and stay in MEM_WAIT.
REQ-018 MEM_WAIT, MemReadyM=1: SHALL deassert StallE/M and go to RUN; lwHaz/PCSrcE SHALL then be handled as in REQ-015/016 in that same cycle.
REQ-019 SHALL set a flushPending flop when PCSrcE=1 in any memHold cycle, including the entry cycle.
REQ-020 On the release cycle, SHALL assert FlushD/E if PCSrcE | flushPending, and clear flushPending.
REQ-021 SHALL increment an 8-bit waitCnt each cycle memHold=1, and clear it when memHold=0; waitCnt saturates at 255.
REQ-022 SHALL set MemTimeout when waitCnt reaches MEM_TIMEOUT; MemTimeout stays set until reset and never alters stall behaviour.
REQ-023 SHALL have MemReqM=0 while in MEM_WAIT be treated as MemReadyM=1, so the FSM releases.

Reset
REQ-024 rst_n low SHALL asynchronously force state=RUN, flushPending=0, waitCnt=0, MemTimeout=0, and all counters 0.
REQ-025 During reset, combinational outputs SHALL follow the RUN equations with the flops at reset values.
REQ-026 Reset asserted mid MEM_WAIT SHALL discard the pending flush and the wait count.

Configuration
REQ-027 With HAZARD_PERF_CNT_EN defined, SHALL count:
- LoadStallCnt: cycles under REQ-016.
- MemStallCnt: cycles with StallM=1.
- FlushCnt: cycles with FlushE=1.
All three counters wrap modulo 2^CNT_W.
REQ-028 Without HAZARD_PERF_CNT_EN, the counter ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 SHALL place the state enum (RUN, MEM_WAIT) and the default MEM_TIMEOUT constant in the shared pipeline package.
REQ-030 SHALL implement the timeout counter and sticky flag as sub-module mem_wait_timer (inputs clk, rst_n, memHold; output MemTimeout).

Verification
REQ-031 LoadE=1, RegWriteE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 and StallE=StallM=0 for exactly that cycle; LoadStallCnt +1.
REQ-032 Same as REQ-031 but RdE=0 and Rs1D=0 -> no stall, no flush.
REQ-033 PCSrcE=1 together with a REQ-031 hazard -> FlushD=FlushE=1, StallF=StallD=0.
REQ-034 MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all stalls high for 3 cycles, low on the 4th; state RUN after; MemStallCnt=3.
REQ-035 PCSrcE pulse on the 2nd cycle of a 4-cycle memHold -> no flush while stalled; FlushD=FlushE=1 on the release cycle only.
REQ-036 memHold held for 20 cycles with MEM_TIMEOUT=16 -> MemTimeout rises after the 16th cycle and stays high after release; rst_n pulse mid-wait clears it and returns to RUN.
